// File: rtl/sphere_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sphere_pkg
// Purpose  : Shared types, constants and helpers for the sphere state file.
// Revision : 1.0 - initial release
// ============================================================================
package sphere_pkg;

    typedef logic [63:0]      fixed_real;   // 32.32 signed fixed point
    typedef logic [2:0][63:0] vector;       // {x, y, z} = [2], [1], [0]
    typedef logic [2:0][7:0]  color;        // {r, g, b}

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_UPDATE = 1'b1
    } state_t;

    localparam vector ZERO_VEC = '0;

    function automatic fixed_real to_fixed(input int value);
        return {value, 32'd0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sphere_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : sphere_lfsr
// Purpose  : 64-bit Galois LFSR (taps 64,63,61,60) stepping every clock.
// Revision : 1.0 - initial release
// ============================================================================
module sphere_lfsr (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] random
);

    localparam logic [63:0] SEED = 64'hACE1_2468_1357_BDF9;
    localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            random <= SEED;
        end else begin
            random <= (random >> 1) ^ (random[0] ? TAPS : 64'd0);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sphere_reg_n.sv
`default_nettype none
// ============================================================================
// Module   : sphere_reg_n
// Purpose  : N-sphere pos/vel/colour state file with a one-sphere-per-clock
//            physics engine, respawn logic and a registered read port.
//            Optional floor bounce when SPHERE_BOUNCE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module sphere_reg_n
    import sphere_pkg::*;
#(
    parameter int          N_SPHERES = 8,
    parameter logic [63:0] GRAVITY   = 64'h0000_0000_0001_0000,
    parameter int          SPAWN_Y   = 304,
    parameter int          LIMIT     = 1440,
    localparam int         IW        = $clog2(N_SPHERES)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Frame_Clk,
    input  logic          Hit,
    input  logic [IW-1:0] Hit_index,
    input  logic [IW-1:0] Read_index,
    output logic [191:0]  Sphere_pos,
    output logic [23:0]   Sphere_col,
    output logic [IW-1:0] curr_index,
    output logic          Busy,
    output logic          Frame_Done
);

    localparam vector         SPAWN_VEC = {64'd0, to_fixed(SPAWN_Y), 64'd0};
    localparam fixed_real     LIM_POS   = to_fixed(LIMIT);
    localparam fixed_real     LIM_NEG   = 64'd0 - LIM_POS;
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_SPHERES - 1);
    localparam color          WHITE     = 24'hFF_FFFF;

    vector                pos [N_SPHERES];
    vector                vel [N_SPHERES];
    color                 col [N_SPHERES];
    logic [N_SPHERES-1:0] respawn_pend;
    logic [N_SPHERES-1:0] respawn_pend_next;

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_next;
    logic          frame_clk_old;
    logic          step_pend;
    logic          step_pend_next;
    logic          frame_done_next;
    logic          fe;

    logic [63:0] rnd;
    logic        unused_rnd;
    vector       vel_n;
    vector       pos_n;
    vector       new_pos;
    vector       new_vel;
    color        new_col;
    logic        leaving_xz;
    logic        leaving;
    logic        respawn;
    logic        hit_valid;
    logic        read_valid;

    sphere_lfsr u_lfsr (
        .clk    (Clk),
        .rst    (Reset),
        .random (rnd)
    );

    assign unused_rnd = ^rnd[15:2];
    assign fe         = Frame_Clk & ~frame_clk_old;
    assign Busy       = (state == S_UPDATE);
    assign hit_valid  = Hit && (int'(Hit_index) < N_SPHERES);
    assign read_valid = int'(Read_index) < N_SPHERES;

    // Shared step datapath for the sphere selected by idx.
    always_comb begin
        vel_n    = vel[idx];
        vel_n[1] = vel[idx][1] - GRAVITY;
        for (int k = 0; k < 3; k++) begin
            pos_n[k] = pos[idx][k] + vel_n[k];
        end

        leaving_xz = ($signed(pos_n[2]) > $signed(LIM_POS)) || ($signed(pos_n[2]) < $signed(LIM_NEG)) ||
                     ($signed(pos_n[0]) > $signed(LIM_POS)) || ($signed(pos_n[0]) < $signed(LIM_NEG));
`ifdef SPHERE_BOUNCE_EN
        leaving = leaving_xz;
`else
        leaving = leaving_xz || ($signed(pos_n[1]) < $signed(LIM_NEG));
`endif
        respawn = respawn_pend[idx] | (Hit & (Hit_index == idx)) | leaving;

        new_pos = pos_n;
        new_vel = vel_n;
        new_col = col[idx];
`ifdef SPHERE_BOUNCE_EN
        if (pos_n[1][63]) begin
            new_pos[1] = '0;
            new_vel[1] = 64'd0 - fixed_real'($signed(vel_n[1]) >>> 1);
        end
`endif
        if (respawn) begin
            new_pos    = SPAWN_VEC;
            new_vel[2] = {{30{rnd[0]}}, rnd[47:32], 18'b0};
            new_vel[1] = {30'b0, rnd[63:48], 18'b0};
            new_vel[0] = {{30{rnd[1]}}, rnd[31:16], 18'b0};
            new_col    = rnd[63:40];
        end
    end

    // Clearing after setting makes a hit on the sphere in flight end cleared.
    always_comb begin
        respawn_pend_next = respawn_pend;
        if (hit_valid) begin
            respawn_pend_next[Hit_index] = 1'b1;
        end
        if (Busy && respawn) begin
            respawn_pend_next[idx] = 1'b0;
        end
    end

    always_comb begin
        state_next      = state;
        idx_next        = idx;
        step_pend_next  = step_pend;
        frame_done_next = 1'b0;
        case (state)
            S_IDLE: begin
                if (fe || step_pend) begin
                    state_next     = S_UPDATE;
                    idx_next       = '0;
                    step_pend_next = 1'b0;
                end
            end
            S_UPDATE: begin
                if (fe) begin
                    step_pend_next = 1'b1;
                end
                if (idx == LAST_IDX) begin
                    state_next      = S_IDLE;
                    frame_done_next = 1'b1;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= S_IDLE;
            idx           <= '0;
            step_pend     <= 1'b0;
            frame_clk_old <= 1'b0;
            Frame_Done    <= 1'b0;
        end else begin
            state         <= state_next;
            idx           <= idx_next;
            step_pend     <= step_pend_next;
            frame_clk_old <= Frame_Clk;
            Frame_Done    <= frame_done_next;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < N_SPHERES; i++) begin
                pos[i] <= SPAWN_VEC;
                vel[i] <= ZERO_VEC;
                col[i] <= WHITE;
            end
            respawn_pend <= '1;
        end else begin
            if (Busy) begin
                pos[idx] <= new_pos;
                vel[idx] <= new_vel;
                col[idx] <= new_col;
            end
            respawn_pend <= respawn_pend_next;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Sphere_pos <= '0;
            Sphere_col <= '0;
            curr_index <= '0;
        end else begin
            curr_index <= Read_index;
            if (read_valid) begin
                Sphere_pos <= pos[Read_index];
                Sphere_col <= col[Read_index];
            end else begin
                Sphere_pos <= ZERO_VEC;
                Sphere_col <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sphere_reg_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_sphere_reg_n
// Purpose  : Randomized bench for sphere_reg_n against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sphere_reg_n;

    localparam int     N     = 6;
    localparam int     IW    = 3;
    localparam longint GRAV  = 64'sd65536;
    localparam longint SPAWN = 64'sd304 <<< 32;
    localparam longint LIM   = 64'sd1440 <<< 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_clk;
    logic          hit;
    logic [IW-1:0] hit_index;
    logic [IW-1:0] read_index;
    logic [191:0]  sphere_pos;
    logic [23:0]   sphere_col;
    logic [IW-1:0] curr_index;
    logic          busy;
    logic          frame_done;

    sphere_reg_n #(.N_SPHERES(N)) dut (
        .Clk        (clk),
        .Reset      (rst),
        .Frame_Clk  (frame_clk),
        .Hit        (hit),
        .Hit_index  (hit_index),
        .Read_index (read_index),
        .Sphere_pos (sphere_pos),
        .Sphere_col (sphere_col),
        .curr_index (curr_index),
        .Busy       (busy),
        .Frame_Done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: component 0 = x, 1 = y, 2 = z.
    longint        m_pos [N][3];
    longint        m_vel [N][3];
    logic [23:0]   m_col [N];
    bit            m_pend [N];
    logic [63:0]   m_lfsr;
    bit            m_fc_old;
    bit            m_step_req;
    longint        m_cycle;
    longint        m_start;
    logic [191:0]  e_pos;
    logic [23:0]   e_col;
    logic [IW-1:0] e_ci;
    bit            e_busy;
    bit            e_done;

    task automatic check_val(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [63:0] lfsr_next(input logic [63:0] x);
        return (x >> 1) ^ (x[0] ? 64'hD800_0000_0000_0000 : 64'd0);
    endfunction

    function automatic bit beyond(input longint v);
        return (v > LIM) || (v < -LIM);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pos[i]  = '{0, SPAWN, 0};
            m_vel[i]  = '{0, 0, 0};
            m_col[i]  = 24'hFF_FFFF;
            m_pend[i] = 1'b1;
        end
        m_lfsr     = 64'hACE1_2468_1357_BDF9;
        m_fc_old   = 1'b0;
        m_step_req = 1'b0;
        m_cycle    = 0;
        m_start    = -1000;
        e_pos      = '0;
        e_col      = '0;
        e_ci       = '0;
        e_busy     = 1'b0;
        e_done     = 1'b0;
    endtask

    task automatic model_sphere(input int i);
        longint      vn [3];
        longint      pn [3];
        logic [63:0] r;
        bit          gone;
        bit          resp;
        vn    = m_vel[i];
        vn[1] = vn[1] - GRAV;
        for (int k = 0; k < 3; k++) pn[k] = m_pos[i][k] + vn[k];
        gone = beyond(pn[0]) || beyond(pn[2]);
`ifndef SPHERE_BOUNCE_EN
        gone = gone || (pn[1] < -LIM);
`endif
        resp = m_pend[i] || (hit && int'(hit_index) == i) || gone;
        if (resp) begin
            r           = m_lfsr;
            m_pos[i]    = '{0, SPAWN, 0};
            m_vel[i][0] = (longint'(r[47:32]) <<< 18) - (r[0] ? (64'sd1 <<< 34) : 64'sd0);
            m_vel[i][1] = longint'(r[63:48]) <<< 18;
            m_vel[i][2] = (longint'(r[31:16]) <<< 18) - (r[1] ? (64'sd1 <<< 34) : 64'sd0);
            m_col[i]    = r[63:40];
            m_pend[i]   = 1'b0;
        end else begin
`ifdef SPHERE_BOUNCE_EN
            if (pn[1] < 0) begin
                pn[1] = 0;
                vn[1] = -(vn[1] >>> 1);
            end
`endif
            m_pos[i] = pn;
            m_vel[i] = vn;
        end
    endtask

    // One clock edge: sphere (cycle - start) is written in each busy cycle.
    task automatic model_step();
        int  rd;
        int  hi;
        int  cur;
        bit  fe;
        bit  in_step;
        rd = int'(read_index);
        if (rd < N) begin
            e_pos = {m_pos[rd][0], m_pos[rd][1], m_pos[rd][2]};
            e_col = m_col[rd];
        end else begin
            e_pos = '0;
            e_col = '0;
        end
        e_ci     = read_index;
        fe       = frame_clk && !m_fc_old;
        m_fc_old = frame_clk;
        in_step  = (m_cycle >= m_start) && (m_cycle < m_start + N);
        cur      = int'(m_cycle - m_start);
        if (in_step) model_sphere(cur);
        hi = int'(hit_index);
        if (hit && hi < N && !(in_step && hi == cur)) m_pend[hi] = 1'b1;
        if (in_step) begin
            if (fe) m_step_req = 1'b1;
        end else if (fe || m_step_req) begin
            m_start    = m_cycle + 1;
            m_step_req = 1'b0;
        end
        m_lfsr  = lfsr_next(m_lfsr);
        m_cycle = m_cycle + 1;
        e_busy  = (m_cycle >= m_start) && (m_cycle < m_start + N);
        e_done  = (m_cycle == m_start + N);
    endtask

    task automatic compare_outputs();
        check_val("sphere_pos", sphere_pos, e_pos);
        check_val("sphere_col", sphere_col, e_col);
        check_val("curr_index", curr_index, e_ci);
        check_val("busy",       busy,       e_busy);
        check_val("frame_done", frame_done, e_done);
    endtask

    task automatic cycle(input bit fc, input bit h, input int hi, input int ri);
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
        frame_clk  = fc;
        hit        = h;
        hit_index  = IW'(hi);
        read_index = IW'(ri);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic release_reset();
        @(posedge clk);
        model_reset();
        #1 rst = 1'b0;
        @(negedge clk);
        compare_outputs();
    endtask

    initial begin
        rst        = 1'b1;
        frame_clk  = 1'b0;
        hit        = 1'b0;
        hit_index  = '0;
        read_index = '0;
        model_reset();
        @(negedge clk);
        compare_outputs();
        release_reset();

        repeat (2) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < N + 4; i++) cycle(0, 0, 0, i % 8);

        // Hits while idle, one valid and one beyond the sphere count.
        cycle(0, 1, 5, 5);
        cycle(0, 1, 7, 3);
        cycle(1, 0, 0, 5);
        for (int i = 0; i < N + 4; i++) cycle(0, 0, 0, i % 8);

        // Several edges inside one update collapse into a single extra step.
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 2);
        cycle(0, 0, 0, 3);
        cycle(1, 0, 0, 4);
        for (int i = 0; i < 3 * N; i++) cycle(0, 0, 0, i % 8);

        // Long run so spheres drift beyond the arena and respawn.
        for (int i = 0; i < 20000; i++) begin
            cycle($urandom_range(1, 0), $urandom_range(999, 0) == 0,
                  $urandom_range(7, 0), $urandom_range(7, 0));
        end

        // Reset in the middle of an update.
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 2);
        @(posedge clk);
        model_step();
        #2;
        rst       = 1'b1;
        frame_clk = 1'b0;
        model_reset();
        @(negedge clk);
        compare_outputs();
        repeat (2) cycle(0, 0, 0, 0);
        release_reset();
        repeat (3) cycle(0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(1, 0), $urandom_range(29, 0) == 0,
                  $urandom_range(7, 0), $urandom_range(7, 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
